// File: rtl/sinegen_pkg.sv
// Shared widths and types for the sine generator datapath.
// Defaults match the standard ROM configuration.
package sinegen_pkg;

    localparam int ADDRESS_WIDTH = 8;
    localparam int ACC_WIDTH     = 16;
    localparam int ROM_LATENCY   = 1;
    localparam int ADDR_LSB      = ACC_WIDTH - ADDRESS_WIDTH;

    typedef logic [ADDRESS_WIDTH-1:0] addr_t;
    typedef logic [ACC_WIDTH-1:0]     acc_t;

endpackage

// File: rtl/valid_delay.sv
// Delays a valid bit by DEPTH cycles to align it with registered ROM data.
// Latency: DEPTH cycles. No backpressure; async reset clears every stage.
module valid_delay #(
    parameter int DEPTH = 1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic din,
    output logic dout
);

    logic [DEPTH-1:0] sr_q;
    logic [DEPTH-1:0] sr_d;

    always_comb begin
        sr_d    = sr_q;
        sr_d[0] = din;
        for (int i = 1; i < DEPTH; i++) begin
            sr_d[i] = sr_q[i-1];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sr_q <= '0;
        end else begin
            sr_q <= sr_d;
        end
    end

    assign dout = sr_q[DEPTH-1];

endmodule

// File: rtl/phase_addr_gen.sv
// Phase accumulator driving both address ports of the dual-port sine ROM.
// Latency: 1 cycle to addresses, 1+ROM_LATENCY to data valid. No backpressure.
module phase_addr_gen
    import sinegen_pkg::*;
#(
    parameter int ADDRESS_WIDTH = sinegen_pkg::ADDRESS_WIDTH,
    parameter int ACC_WIDTH     = sinegen_pkg::ACC_WIDTH,
    parameter int ROM_LATENCY   = sinegen_pkg::ROM_LATENCY
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     en,
    input  logic [ACC_WIDTH-1:0]     incr,
    input  logic [ADDRESS_WIDTH-1:0] offset,
    input  logic                     offset_ld,
    input  logic                     phase_clr,
    output logic [ADDRESS_WIDTH-1:0] addr1,
    output logic [ADDRESS_WIDTH-1:0] addr2,
    output logic                     addr_valid,
    output logic                     dout_valid,
    output logic                     wrap
);

    logic [ACC_WIDTH-1:0]     acc_q, acc_d;
    logic [ADDRESS_WIDTH-1:0] offset_q, offset_d;
    logic [ADDRESS_WIDTH-1:0] addr1_q, addr1_d;
    logic [ADDRESS_WIDTH-1:0] addr2_q, addr2_d;
    logic                     addr_valid_q, addr_valid_d;
    logic                     wrap_q, wrap_d;
    logic [ADDRESS_WIDTH-1:0] off_eff;
    logic [ACC_WIDTH:0]       sum;

    always_comb begin
        // A freshly loaded offset takes effect on the same edge it is captured.
        off_eff      = offset_ld ? offset : offset_q;
        offset_d     = off_eff;
        sum          = {1'b0, acc_q} + {1'b0, incr};
        acc_d        = acc_q;
        addr1_d      = addr1_q;
        addr2_d      = offset_ld ? (addr1_q + off_eff) : addr2_q;
        addr_valid_d = 1'b0;
        wrap_d       = 1'b0;
        if (phase_clr) begin
            acc_d   = '0;
            addr1_d = '0;
            addr2_d = off_eff;
        end else if (en) begin
            acc_d        = sum[ACC_WIDTH-1:0];
            addr1_d      = sum[ACC_WIDTH-1 -: ADDRESS_WIDTH];
            addr2_d      = addr1_d + off_eff;
            wrap_d       = sum[ACC_WIDTH];
            addr_valid_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q        <= '0;
            offset_q     <= '0;
            addr1_q      <= '0;
            addr2_q      <= '0;
            addr_valid_q <= 1'b0;
            wrap_q       <= 1'b0;
        end else begin
            acc_q        <= acc_d;
            offset_q     <= offset_d;
            addr1_q      <= addr1_d;
            addr2_q      <= addr2_d;
            addr_valid_q <= addr_valid_d;
            wrap_q       <= wrap_d;
        end
    end

    // In-flight valids survive phase_clr; only reset flushes them.
    valid_delay #(
        .DEPTH (ROM_LATENCY)
    ) u_valid_delay (
        .clk   (clk),
        .rst_n (rst_n),
        .din   (addr_valid_q),
        .dout  (dout_valid)
    );

    assign addr1      = addr1_q;
    assign addr2      = addr2_q;
    assign addr_valid = addr_valid_q;
    assign wrap       = wrap_q;

endmodule

// File: tb/tb_phase_addr_gen.sv
// Directed bench for phase_addr_gen with default widths (8-bit address, 16-bit accumulator, ROM latency 1).
module tb_phase_addr_gen;

    logic        clk;
    logic        rst_n;
    logic        en;
    logic [15:0] incr;
    logic [7:0]  offset;
    logic        offset_ld;
    logic        phase_clr;
    logic [7:0]  addr1;
    logic [7:0]  addr2;
    logic        addr_valid;
    logic        dout_valid;
    logic        wrap;

    int checks = 0;
    int errors = 0;

    phase_addr_gen dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .en         (en),
        .incr       (incr),
        .offset     (offset),
        .offset_ld  (offset_ld),
        .phase_clr  (phase_clr),
        .addr1      (addr1),
        .addr2      (addr2),
        .addr_valid (addr_valid),
        .dout_valid (dout_valid),
        .wrap       (wrap)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_outs(input string name, input logic [7:0] e_a1, input logic [7:0] e_a2,
                               input logic e_av, input logic e_dv, input logic e_wr);
        checks++;
        if ({addr1, addr2, addr_valid, dout_valid, wrap} !== {e_a1, e_a2, e_av, e_dv, e_wr}) begin
            errors++;
            $display("FAIL %s: got a1=%h a2=%h av=%b dv=%b wr=%b, want a1=%h a2=%h av=%b dv=%b wr=%b",
                     name, addr1, addr2, addr_valid, dout_valid, wrap, e_a1, e_a2, e_av, e_dv, e_wr);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b1; en = 1'b0; incr = '0; offset = '0; offset_ld = 1'b0; phase_clr = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        expect_outs("reset_async", 8'h00, 8'h00, 1'b0, 1'b0, 1'b0);
        step();
        expect_outs("reset_held", 8'h00, 8'h00, 1'b0, 1'b0, 1'b0);
        rst_n = 1'b1;
        step();
        expect_outs("reset_release_idle", 8'h00, 8'h00, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_basic_step();
        en = 1'b1; incr = 16'h0100;
        for (int i = 1; i <= 4; i++) begin
            step();
            expect_outs($sformatf("basic_step%0d", i), 8'(i), 8'(i), 1'b1, (i >= 2), 1'b0);
        end
        en = 1'b0;
        step();
        expect_outs("basic_stop", 8'h04, 8'h04, 1'b0, 1'b1, 1'b0);
        step();
        expect_outs("basic_drain", 8'h04, 8'h04, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_half_step();
        logic [7:0] exp_a [6] = '{8'h00, 8'h01, 8'h01, 8'h02, 8'h02, 8'h03};
        phase_clr = 1'b1;
        step();
        expect_outs("half_clr", 8'h00, 8'h00, 1'b0, 1'b0, 1'b0);
        phase_clr = 1'b0; en = 1'b1; incr = 16'h0080;
        for (int i = 0; i < 6; i++) begin
            step();
            expect_outs($sformatf("half_step%0d", i), exp_a[i], exp_a[i], 1'b1, (i >= 1), 1'b0);
        end
        en = 1'b0;
        step();
        step();
    endtask

    task automatic test_wrap();
        phase_clr = 1'b1;
        step();
        phase_clr = 1'b0; en = 1'b1; incr = 16'hFF00;
        step();
        expect_outs("wrap_preload", 8'hFF, 8'hFF, 1'b1, 1'b0, 1'b0);
        incr = 16'h0100;
        step();
        expect_outs("wrap_pulse", 8'h00, 8'h00, 1'b1, 1'b1, 1'b1);
        incr = 16'h0000;
        step();
        expect_outs("wrap_incr0", 8'h00, 8'h00, 1'b1, 1'b1, 1'b0);
        en = 1'b0;
        step();
        expect_outs("wrap_gone", 8'h00, 8'h00, 1'b0, 1'b1, 1'b0);
        step();
    endtask

    task automatic test_offset();
        phase_clr = 1'b1;
        step();
        phase_clr = 1'b0; en = 1'b1; incr = 16'hF000; offset = 8'd64; offset_ld = 1'b1;
        step();
        expect_outs("offset_same_edge", 8'hF0, 8'h30, 1'b1, 1'b0, 1'b0);
        en = 1'b0; offset_ld = 1'b0; offset = 8'hAA;
        step();
        expect_outs("offset_hold", 8'hF0, 8'h30, 1'b0, 1'b1, 1'b0);
        offset = 8'h00; offset_ld = 1'b1;
        step();
        expect_outs("offset_reload_idle", 8'hF0, 8'hF0, 1'b0, 1'b0, 1'b0);
        offset_ld = 1'b0;
    endtask

    task automatic test_clr_priority();
        offset = 8'h10; offset_ld = 1'b1;
        step();
        expect_outs("clr_load_off", 8'hF0, 8'h00, 1'b0, 1'b0, 1'b0);
        offset_ld = 1'b0; offset = 8'h00; en = 1'b1; incr = 16'h0100;
        step();
        expect_outs("clr_prestep", 8'hF1, 8'h01, 1'b1, 1'b0, 1'b0);
        phase_clr = 1'b1;
        step();
        expect_outs("clr_over_en", 8'h00, 8'h10, 1'b0, 1'b1, 1'b0);
        phase_clr = 1'b0; en = 1'b0;
        step();
        expect_outs("clr_after", 8'h00, 8'h10, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_async_reset();
        en = 1'b1; incr = 16'h0100;
        for (int i = 1; i <= 3; i++) begin
            step();
            expect_outs($sformatf("stream%0d", i), 8'(i), 8'(i + 8'h10), 1'b1, (i >= 2), 1'b0);
        end
        #2 rst_n = 1'b0;
        #1;
        expect_outs("midrun_reset", 8'h00, 8'h00, 1'b0, 1'b0, 1'b0);
        #1 en = 1'b0;
        #1 rst_n = 1'b1;
        step();
        expect_outs("post_reset1", 8'h00, 8'h00, 1'b0, 1'b0, 1'b0);
        step();
        expect_outs("post_reset2", 8'h00, 8'h00, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        test_reset();
        test_basic_step();
        test_half_step();
        test_wrap();
        test_offset();
        test_clr_priority();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
